// File: rtl/input_state.sv
// Player input capture: conditions the four colour buttons, then checks each press
// against the stored colour sequence for the current round.
module input_state #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n_input,
  input  logic        en_input,
  input  logic [31:0] seq_in_input,
  input  logic [3:0]  round_ctr,
  input  logic [3:0]  btn_in,
  output logic [1:0]  colour_bus,
  output logic        colour_oe,
  output logic        press_valid,
  output logic        complete_input,
  output logic        fail_input,
  output logic        timeout_input
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmW-1:0] TmMax = TmW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StCapture} state_e;

  state_e         r_state, w_state_next;
  logic [3:0]     r_sync1, r_btn_s, r_btn_s_prev;
  logic [DbW-1:0] r_db_cnt;
  logic [3:0]     r_btn_db, r_btn_db_prev;
  logic [3:0]     r_pos, w_pos_next;
  logic [TmW-1:0] r_timer, w_timer_next;

  logic           r_press_valid, w_press_valid_next;
  logic           r_complete, w_complete_next;
  logic           r_fail, w_fail_next;
  logic           r_timeout, w_timeout_next;
  logic           r_colour_oe, w_colour_oe_next;
  logic [1:0]     r_colour_bus, w_colour_bus_next;

  logic [1:0]     w_colour;
  logic           w_onehot;
  logic           w_press;
  logic [1:0]     w_expected;

  // Input conditioning: 2-flop synchronizer, stability counter, debounced vector.
  always_ff @(posedge clk or negedge rst_n_input) begin
    if (!rst_n_input) begin
      r_sync1       <= '0;
      r_btn_s       <= '0;
      r_btn_s_prev  <= '0;
      r_db_cnt      <= '0;
      r_btn_db      <= '0;
      r_btn_db_prev <= '0;
    end else begin
      r_sync1       <= btn_in;
      r_btn_s       <= r_sync1;
      r_btn_s_prev  <= r_btn_s;
      r_btn_db_prev <= r_btn_db;
      if (r_btn_s != r_btn_s_prev) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != DbMax) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      // Only a vector that is still stable this cycle may be committed.
      if ((r_db_cnt == DbMax) && (r_btn_s == r_btn_s_prev)) begin
        r_btn_db <= r_btn_s;
      end
    end
  end

  always_comb begin
    w_colour = 2'b00;
    w_onehot = 1'b0;
    case (r_btn_db)
      4'b0001: begin w_colour = 2'b00; w_onehot = 1'b1; end
      4'b0010: begin w_colour = 2'b01; w_onehot = 1'b1; end
      4'b0100: begin w_colour = 2'b10; w_onehot = 1'b1; end
      4'b1000: begin w_colour = 2'b11; w_onehot = 1'b1; end
      default: begin w_colour = 2'b00; w_onehot = 1'b0; end
    endcase
  end

  assign w_press    = |(r_btn_db & ~r_btn_db_prev);
  assign w_expected = seq_in_input[{r_pos, 1'b0} +: 2];

  always_comb begin
    w_state_next       = r_state;
    w_pos_next         = r_pos;
    w_timer_next       = r_timer;
    w_press_valid_next = 1'b0;
    w_complete_next    = 1'b0;
    w_fail_next        = 1'b0;
    w_timeout_next     = r_timeout;

    case (r_state)
      StIdle: begin
        if (en_input) begin
          w_pos_next     = '0;
          w_timer_next   = '0;
          w_timeout_next = 1'b0;
          w_state_next   = StCapture;
        end
      end
      StCapture: begin
        w_timer_next = r_timer + 1'b1;
        // A press in the final timer cycle takes priority over the timeout.
        if (w_press) begin
          w_press_valid_next = 1'b1;
          if (!w_onehot || (w_colour != w_expected)) begin
            w_fail_next  = 1'b1;
            w_state_next = StIdle;
          end else if (r_pos == round_ctr) begin
            w_complete_next = 1'b1;
            w_state_next    = StIdle;
          end else begin
            w_pos_next   = r_pos + 4'd1;
            w_timer_next = '0;
          end
        end else if (r_timer == TmMax) begin
          w_fail_next    = 1'b1;
          w_timeout_next = 1'b1;
          w_state_next   = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_colour_oe_next  = (r_state == StCapture) && w_onehot;
    w_colour_bus_next = w_colour_oe_next ? w_colour : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n_input) begin
    if (!rst_n_input) begin
      r_state       <= StIdle;
      r_pos         <= '0;
      r_timer       <= '0;
      r_press_valid <= 1'b0;
      r_complete    <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_colour_oe   <= 1'b0;
      r_colour_bus  <= 2'b00;
    end else begin
      r_state       <= w_state_next;
      r_pos         <= w_pos_next;
      r_timer       <= w_timer_next;
      r_press_valid <= w_press_valid_next;
      r_complete    <= w_complete_next;
      r_fail        <= w_fail_next;
      r_timeout     <= w_timeout_next;
      r_colour_oe   <= w_colour_oe_next;
      r_colour_bus  <= w_colour_bus_next;
    end
  end

  assign colour_bus     = r_colour_bus;
  assign colour_oe      = r_colour_oe;
  assign press_valid    = r_press_valid;
  assign complete_input = r_complete;
  assign fail_input     = r_fail;
  assign timeout_input  = r_timeout;

endmodule

// File: tb/tb_input_state.sv
// Scoreboard bench for input_state: expected pulse events are queued as buttons are
// driven and matched, cycle-exact, against pulses observed on the outputs.
module tb_input_state;

  localparam int unsigned Db  = 4;
  localparam int unsigned To  = 64;
  // Drive cycle to press_valid: 1 to first sampling edge, then 2 + Db + 1.
  localparam int unsigned Lat = Db + 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic        pv;
    logic        comp;
    logic        fail;
    logic        to;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] seq;
  logic [3:0]  rc;
  logic [3:0]  btn;
  logic [1:0]  colour_bus;
  logic        colour_oe, press_valid, complete_input, fail_input, timeout_input;

  logic [31:0] cyc = '0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  ev_t         e, o;
  int          n_checks = 0;
  int          n_fail   = 0;

  input_state #(
    .DEBOUNCE_CYCLES(Db),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .clk           (clk),
    .rst_n_input   (rst_n),
    .en_input      (en),
    .seq_in_input  (seq),
    .round_ctr     (rc),
    .btn_in        (btn),
    .colour_bus    (colour_bus),
    .colour_oe     (colour_oe),
    .press_valid   (press_valid),
    .complete_input(complete_input),
    .fail_input    (fail_input),
    .timeout_input (timeout_input)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (press_valid || complete_input || fail_input)
      obs_q.push_back('{cyc, press_valid, complete_input, fail_input, timeout_input});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    en = 1'b1;
    step(1);
    en = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input bit ev, input bit comp, input bit fail);
    if (ev) exp_q.push_back('{cyc + Lat, 1'b1, comp, fail, 1'b0});
    btn = b;
    step(12);
    btn = 4'b0000;
    step(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; btn = 4'b0000; seq = '0; rc = '0;
    step(3);
    n_checks++;
    if ({colour_bus, colour_oe, press_valid, complete_input, fail_input, timeout_input} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {colour_bus, colour_oe, press_valid, complete_input, fail_input, timeout_input});
    end
    rst_n = 1'b1;
    step(6);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_correct_round();
    seq = 32'h0000_00E4; rc = 4'd3;
    start_round();
    press(4'b0001, 1, 0, 0);
    press(4'b0010, 1, 0, 0);
    press(4'b0100, 1, 0, 0);
    press(4'b1000, 1, 1, 0);
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL correct_round: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL correct_round: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL correct_round_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_wrong_colour();
    seq = 32'h0000_00E4; rc = 4'd3;
    start_round();
    press(4'b0001, 1, 0, 0);
    press(4'b0100, 1, 0, 1);
    press(4'b1000, 0, 0, 0);
    step(To + 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL wrong_colour: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL wrong_colour: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrong_colour_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_bounce_multi();
    logic [31:0] k;
    seq = 32'h0000_0001; rc = 4'd0;
    start_round();
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step(2);
    end
    exp_q.push_back('{k + 20 + Lat, 1'b1, 1'b1, 1'b0, 1'b0});
    btn = 4'b0010;
    step(12);
    btn = 4'b0000;
    step(12);
    seq = 32'h0000_00E4; rc = 4'd3;
    start_round();
    press(4'b0011, 1, 0, 1);
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL bounce_multi: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL bounce_multi: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_multi_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    logic [31:0] s;
    seq = 32'h0000_00E4; rc = 4'd0;
    s = cyc;
    start_round();
    exp_q.push_back('{s + 1 + To, 1'b0, 1'b0, 1'b1, 1'b1});
    step(To + 10);
    n_checks++;
    if (timeout_input !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_held: got %b expected 1", timeout_input);
    end
    s = cyc;
    start_round();
    n_checks++;
    if (timeout_input !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cleared: got %b expected 0", timeout_input);
    end
    // Debounced edge lands exactly in the cycle the timer hits its limit.
    step(56);
    press(4'b0001, 1, 1, 0);
    step(10);
    n_checks++;
    if (timeout_input !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_race_flag: got %b expected 0", timeout_input);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL timeout: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL timeout: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_max_round();
    seq = 32'hFFFF_FFFF; rc = 4'd15;
    start_round();
    for (int i = 0; i < 16; i++) begin
      if (i == 7 || i == 12) begin
        exp_q.push_back('{cyc + Lat, 1'b1, 1'b0, 1'b0, 1'b0});
        btn = 4'b1000;
        en  = 1'b1;
        step(1);
        en  = 1'b0;
        step(11);
        btn = 4'b0000;
        step(12);
      end else begin
        press(4'b1000, 1, (i == 15), 0);
      end
    end
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL max_round: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL max_round: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL max_round_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_async_reset();
    seq = 32'h0000_0002; rc = 4'd3;
    start_round();
    exp_q.push_back('{cyc + Lat, 1'b1, 1'b0, 1'b0, 1'b0});
    btn = 4'b0100;
    step(10);
    n_checks++;
    if ({colour_oe, colour_bus} !== 3'b110) begin
      n_fail++;
      $display("FAIL feedback: got oe=%b bus=%b expected oe=1 bus=10", colour_oe, colour_bus);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({colour_bus, colour_oe, press_valid, complete_input, fail_input, timeout_input} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0000000",
               {colour_bus, colour_oe, press_valid, complete_input, fail_input, timeout_input});
    end
    step(2);
    rst_n = 1'b1;
    step(10);
    btn = 4'b0000;
    step(To + 20);
    n_checks++;
    if (timeout_input !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_timeout: got %b expected 0", timeout_input);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL async_reset_ev: got no event expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL async_reset_ev: got cyc=%0d pv=%b c=%b f=%b t=%b expected cyc=%0d pv=%b c=%b f=%b t=%b",
                   o.cyc, o.pv, o.comp, o.fail, o.to, e.cyc, e.pv, e.comp, e.fail, e.to);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_reset_extra: got %0d extra events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_correct_round();
    test_wrong_colour();
    test_bounce_multi();
    test_timeout();
    test_max_round();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_state.md
Name: input_state

Overview:
- Player-side counterpart of the colour display stage: captures the player's button presses for the current round and checks each against the stored sequence.
- Sits between the four colour-button pads and the game controller.
- Pulses `complete_input` when all N+1 colours are entered correctly, or `fail_input` on a wrong, ambiguous or late press.
- Also drives the pressed colour onto the LED feedback bus.

Parameters:
- DEBOUNCE_CYCLES, 16, cycles the synchronized button vector must be stable before the debounced vector updates; minimum 2.
- TIMEOUT_CYCLES, 1000000, maximum cycles allowed between round start or the last accepted press and the next press; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n_input  input  1  asynchronous active-low reset
- en_input  input  1  start capture for a round; sampled only in IDLE
- seq_in_input  input  32  16 colours packed LSB-first; colour k = bits [2k+1:2k]
- round_ctr  input  4  N, meaning expect N+1 presses (colours 0..N)
- btn_in  input  4  raw asynchronous buttons, one-hot, active-high
- colour_bus  output  2  colour of the currently held button
- colour_oe  output  1  1 means colour_bus is valid (LED feedback on)
- press_valid  output  1  1-cycle pulse per evaluated press
- complete_input  output  1  1-cycle pulse: round entered correctly
- fail_input  output  1  1-cycle pulse: wrong, multi-button or timeout
- timeout_input  output  1  qualifies fail_input; 1 means the failure was a timeout; held until the next start

Behaviour:
- Reset is asynchronous, active-low. On assertion:
  - all outputs = 0;
  - state = IDLE; pos = 0; timer = 0; debounce counter = 0;
  - synchronizer flops, previous-synchronized vector, debounced vector and edge register = 0.
  - Reset mid-round abandons the round with no pulse.
- Input conditioning:
  - 2-flop synchronizer on btn_in gives btn_s.
  - Debounce counter resets to 0 whenever btn_s differs from its previous-cycle value; otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1, btn_db <= btn_s.
  - Press event: rise = btn_db & ~btn_db_prev is nonzero. Releases generate no event.
- Colour decode: btn_db[0] -> 00, [1] -> 01, [2] -> 10, [3] -> 11.
- Feedback: registered.
  - colour_oe = 1 and colour_bus = decoded colour while state = CAPTURE and btn_db is exactly one-hot.
  - Otherwise colour_oe = 0 and colour_bus = 00.
- States:
  - IDLE:
    - en_input = 1 → pos <= 0, timer <= 0, timeout_input <= 0, go to CAPTURE.
    - Press events in IDLE are ignored.
  - CAPTURE:
    - en_input is ignored; the round cannot restart until the module is back in IDLE.
    - The timer increments every cycle.
    - On a press event, evaluate in the same cycle; outputs appear on the next edge:
      - press_valid <= 1;
      - if btn_db is not one-hot → fail_input <= 1, go to IDLE;
      - else if the decoded colour != seq_in_input[2*pos +: 2] → fail_input <= 1, go to IDLE;
      - else if pos == round_ctr → complete_input <= 1, go to IDLE;
      - else pos <= pos+1, timer <= 0.
    - If the timer reaches TIMEOUT_CYCLES-1 with no press event that cycle → fail_input <= 1, timeout_input <= 1, go to IDLE, press_valid = 0.
    - A press event in the same cycle as the timeout wins: it is evaluated, and no timeout is reported.
- Pulses: press_valid, complete_input and fail_input default to 0 each cycle.
  - complete_input and fail_input are mutually exclusive.
- Inputs are sampled live: seq_in_input and round_ctr are sampled at each evaluation and must be held stable by the controller for the whole round.
- Latency, button edge to press_valid: 2 (sync) + DEBOUNCE_CYCLES + 1 (evaluation register) cycles.
- A button held from IDLE into CAPTURE produces no event until it is released and pressed again, because the edge is taken on btn_db.
- round_ctr = 15 is valid: 16 presses, pos reaches 15 with no wrap.

Test Plan:
- Reset, then bench runs with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64 (all scenarios below): rst_n_input low mid-CAPTURE, asynchronously → all outputs 0 immediately; no pulse after release.
- Correct round: seq_in_input = 32'h0000_00E4 (colours 0,1,2,3), round_ctr = 3, en_input pulse; clean presses on btn 0,1,2,3 → press_valid ×4, each 7 cycles after its press edge; complete_input pulse on the 4th; fail_input never asserts.
- Wrong colour: same sequence, presses btn0 then btn2 → fail_input = 1 with timeout_input = 0 on the 2nd evaluation; state back in IDLE; a further btn3 press gives no press_valid.
- Bounce and multi-press: btn1 toggling every 2 cycles for 20 cycles, then stable → exactly one press event. btn0|btn1 pressed together as the first press → fail_input.
- Timeout: start round_ctr = 0, no press → fail_input = 1 and timeout_input = 1 exactly 64 cycles after entering CAPTURE. A press landing in the timeout cycle → evaluated, no timeout.
- Max round: round_ctr = 15, seq 32'hFFFF_FFFF, 16 btn3 presses → complete_input only on the 16th; en_input pulses mid-round are ignored (pos is not reset).
